// File: rtl/maple_pkg.sv
// Shared types and constants for the Maple bus receiver.
package maple_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StBitA,
        StBitB,
        StEnd
    } state_e;

    localparam int unsigned START_FALLS = 4;
    localparam int unsigned END_FALLS   = 2;

    // Bit positions inside the registered error-flag vector
    localparam int unsigned ERR_CRC = 0;
    localparam int unsigned ERR_LEN = 1;
    localparam int unsigned ERR_SEQ = 2;
    localparam int unsigned ERR_TMO = 3;

endpackage

// File: rtl/maple_line_filter.sv
// Synchroniser plus deglitch filter for one Maple line; the line idles high.
module maple_line_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall,
    output logic rise
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   filt_q;
    logic                   prev_q;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    // cnt_q counts consecutive samples that disagree with the filtered value
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            cnt_q  <= '0;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= filt_q;
            if (sample == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= sample;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level = filt_q;
    assign fall  = prev_q & ~filt_q;
    assign rise  = ~prev_q & filt_q;

endmodule

// File: rtl/maple_rx_frame.sv
// Maple bus frame receiver: pattern detection, two-phase bit decode, bytes and frame verdict.
module maple_rx_frame
    import maple_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 3,
    parameter int unsigned MAX_BYTES      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               pin1,
    input  logic                               pin5,
    input  logic                               oe,
    input  logic                               arm,
    input  logic                               abort,
    output logic                               active,
    output logic                               start_detected,
    output logic [7:0]                         byte_data,
    output logic                               byte_valid,
    output logic                               frame_done,
    output logic                               frame_ok,
    output logic                               crc_err,
    output logic                               len_err,
    output logic                               seq_err,
    output logic                               timeout_err,
    output logic [$clog2(MAX_BYTES + 1)-1:0]   byte_count
);

    localparam int unsigned BCW = $clog2(MAX_BYTES + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic l1, l5, f1, f5, r1, r5, any_edge;

    maple_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_pin1 (
        .clk  (clk),
        .rst  (rst),
        .pin  (pin1),
        .level(l1),
        .fall (f1),
        .rise (r1)
    );

    maple_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_pin5 (
        .clk  (clk),
        .rst  (rst),
        .pin  (pin5),
        .level(l5),
        .fall (f5),
        .rise (r5)
    );

    assign any_edge = f1 | f5 | r1 | r5;

    state_e           state_q, state_d;
    logic [2:0]       pat_cnt_q, pat_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]       shift_q, shift_d;
    logic [7:0]       acc_q, acc_d;
    logic [BCW-1:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [TCW-1:0]   tmo_q, tmo_d;
    logic             active_q, active_d;
    logic             start_det_q, start_det_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic [3:0]       flags_q, flags_d;

    logic             bit_en, bit_val, end_frame, valid_end;
    logic [3:0]       err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pat_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            tmo_q       <= '0;
            active_q    <= 1'b0;
            start_det_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            pat_cnt_q   <= pat_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            active_q    <= active_d;
            start_det_q <= start_det_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            flags_q     <= flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pat_cnt_d   = pat_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        active_d    = active_q;
        start_det_d = start_det_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        ok_d        = ok_q;
        flags_d     = flags_q;
        bit_en      = 1'b0;
        bit_val     = 1'b0;
        end_frame   = 1'b0;
        valid_end   = 1'b0;
        err         = '0;
        tmo_d       = (state_q == StIdle || any_edge) ? '0 : tmo_q + TCW'(1);

        if (oe) begin
            state_d     = StIdle;
            start_det_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (active_q && f1 && l5) begin
                        state_d   = StStart;
                        pat_cnt_d = '0;
                    end
                end
                StStart: begin
                    if (f5 && pat_cnt_q != 3'd7) pat_cnt_d = pat_cnt_q + 3'd1;
                    if (l1) begin
                        if (l5 && pat_cnt_q == 3'(START_FALLS)) begin
                            state_d     = StBitA;
                            start_det_d = 1'b1;
                            shift_d     = '0;
                            bit_cnt_d   = '0;
                            count_d     = '0;
                            acc_d       = '0;
                            ovf_d       = 1'b0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                // A simultaneous fall on both lines counts as the expected clock
                StBitA: begin
                    if (f1) begin
                        bit_en  = 1'b1;
                        bit_val = l5;
                        state_d = StBitB;
                    end else if (f5) begin
                        if (!l1) begin
                            end_frame    = 1'b1;
                            err[ERR_SEQ] = 1'b1;
                        end else if (bit_cnt_q != 3'd0) begin
                            end_frame    = 1'b1;
                            err[ERR_LEN] = 1'b1;
                        end else begin
                            state_d   = StEnd;
                            pat_cnt_d = '0;
                        end
                    end
                end
                StBitB: begin
                    if (f5) begin
                        bit_en  = 1'b1;
                        bit_val = l1;
                        state_d = StBitA;
                    end else if (f1) begin
                        end_frame    = 1'b1;
                        err[ERR_SEQ] = 1'b1;
                    end
                end
                StEnd: begin
                    if (f1 && pat_cnt_q != 3'd7) pat_cnt_d = pat_cnt_q + 3'd1;
                    if (l5) begin
                        end_frame = 1'b1;
                        if (l1 && pat_cnt_q == 3'(END_FALLS)) begin
                            valid_end    = 1'b1;
                            err[ERR_CRC] = (acc_q != 8'd0);
                            err[ERR_LEN] = ovf_q || (count_q[1:0] != 2'b01) || (count_q == '0);
                        end else begin
                            err[ERR_SEQ] = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            if (state_q != StIdle && !any_edge && tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                end_frame    = 1'b1;
                valid_end    = 1'b0;
                err          = '0;
                err[ERR_TMO] = 1'b1;
            end
        end

        if (bit_en) begin
            shift_d   = {shift_q[5:0], bit_val};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                // Bytes past MAX_BYTES are dropped, but the frame is still decoded to its end
                if (count_q == BCW'(MAX_BYTES)) begin
                    ovf_d = 1'b1;
                end else begin
                    data_d  = {shift_q, bit_val};
                    valid_d = 1'b1;
                    acc_d   = acc_q ^ {shift_q, bit_val};
                    count_d = count_q + BCW'(1);
                end
            end
        end

        if (abort) end_frame = 1'b0;

        if (end_frame) begin
            done_d  = 1'b1;
            flags_d = err;
            ok_d    = valid_end && (err == '0);
            state_d = StIdle;
            if (valid_end) active_d = 1'b0;
        end

        if (abort) begin
            active_d = 1'b0;
            state_d  = StIdle;
        end else if (arm) begin
            active_d    = 1'b1;
            state_d     = StIdle;
            start_det_d = 1'b0;
        end
    end

    assign active         = active_q;
    assign start_detected = start_det_q;
    assign byte_data      = data_q;
    assign byte_valid     = valid_q;
    assign frame_done     = done_q;
    assign frame_ok       = ok_q;
    assign crc_err        = flags_q[ERR_CRC];
    assign len_err        = flags_q[ERR_LEN];
    assign seq_err        = flags_q[ERR_SEQ];
    assign timeout_err    = flags_q[ERR_TMO];
    assign byte_count     = count_q;

endmodule
